// File: rtl/pipe_int_controller.sv
// Multi-source interrupt controller for the pipelined RAT CPU.
// Synchronises and edge-detects interrupt lines, latches them into a pending
// register, masks them, and hands one request at a time to the CPU core.
// The request is held until int_ack; further requests wait for an EOI write.
module pipe_int_controller #(
  parameter int          NUM_SRC     = 8,
  parameter logic [7:0]  MASK_PORT   = 8'hF0,
  parameter logic [7:0]  STATUS_PORT = 8'hF1,
  parameter logic [7:0]  CLEAR_PORT  = 8'hF2,
  parameter logic [7:0]  ID_PORT     = 8'hF3,
  parameter logic [7:0]  EOI_PORT    = 8'hF4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               io_strb,
  input  logic               int_ack,
  output logic               cpu_int,
  output logic [2:0]         int_id,
  output logic [7:0]         io_rd_data,
  output logic               io_rd_hit
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_reg;
  logic               cpu_int_reg;
  logic [2:0]         int_id_reg;
  logic [NUM_SRC-1:0] sync1_reg, sync2_reg, hist_reg;
  logic [1:0]         settle_reg;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] active;
  logic [7:0]         pending_pad, mask_pad;
  logic [2:0]         sel_id;
  logic               wr_mask, wr_clear, wr_eoi, ack_fire;

  assign wr_mask  = io_strb && (port_id == MASK_PORT);
  assign wr_clear = io_strb && (port_id == CLEAR_PORT);
  assign wr_eoi   = io_strb && (port_id == EOI_PORT);
  assign ack_fire = (state_reg == REQ) && int_ack;
  assign active   = pending_reg & mask_reg;

  // Edges are ignored until the synchroniser and history flops have refilled
  // after reset, so a line held high through reset is seen as a level only.
  assign edge_det = (settle_reg == 2'd3) ? (sync2_reg & ~hist_reg) : '0;

  // Zero-extend the per-source registers to the 8-bit bus width
  always_comb begin
    pending_pad                = '0;
    mask_pad                   = '0;
    pending_pad[NUM_SRC-1:0]   = pending_reg;
    mask_pad[NUM_SRC-1:0]      = mask_reg;
  end

  // Two-flop synchroniser, history flop and post-reset settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      hist_reg   <= '0;
      settle_reg <= '0;
    end else begin
      sync1_reg <= irq_in;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
      if (settle_reg != 2'd3)
        settle_reg <= settle_reg + 2'd1;
    end
  end

  // Per-bit pending update: new edge beats write-1-clear beats ack clear
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      always_comb begin
        pending_next[gi] = pending_reg[gi];
        if (ack_fire && (int_id_reg == 3'(gi)))
          pending_next[gi] = 1'b0;
        if (wr_clear && out_port[gi])
          pending_next[gi] = 1'b0;
        if (edge_det[gi])
          pending_next[gi] = 1'b1;
      end
    end
  endgenerate

  // Pending and mask registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      mask_reg    <= '0;
    end else begin
      pending_reg <= pending_next;
      if (wr_mask)
        mask_reg <= out_port[NUM_SRC-1:0];
    end
  end

  // Priority encoder: lowest enabled pending index wins
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (active[i])
        sel_id = 3'(i);
  end

  // Request FSM with registered cpu_int and int_id
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cpu_int_reg <= 1'b0;
      int_id_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|active) begin
            int_id_reg  <= sel_id;
            state_reg   <= REQ;
            cpu_int_reg <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_reg   <= SERVICE;
            cpu_int_reg <= 1'b0;
          end else if (!pending_pad[int_id_reg] || !mask_pad[int_id_reg]) begin
            state_reg   <= IDLE;
            cpu_int_reg <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr_eoi)
            state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          cpu_int_reg <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read mux for the CPU in_port
  always_comb begin
    io_rd_data = 8'h00;
    io_rd_hit  = 1'b0;
    case (port_id)
      MASK_PORT:   begin io_rd_data = mask_pad;            io_rd_hit = 1'b1; end
      STATUS_PORT: begin io_rd_data = pending_pad;         io_rd_hit = 1'b1; end
      ID_PORT:     begin io_rd_data = {5'b0, int_id_reg};  io_rd_hit = 1'b1; end
      default:     begin io_rd_data = 8'h00;               io_rd_hit = 1'b0; end
    endcase
  end

  assign cpu_int = cpu_int_reg;
  assign int_id  = int_id_reg;

endmodule
